// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, dcache address layout and miss-controller states.
package cpu_types_pkg;

    localparam int DCACHE_SETS = 8;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        FETCH0,
        FETCH1,
        FILL,
        FL_CHK,
        FL_WB0,
        FL_WB1,
        FL_NXT,
        FLUSHED
    } dcache_state_t;

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Dcache miss/flush sequencer: victim writeback, block refill and halt-time flush
// between the frame arrays and the memory-control dcache port.
module dcache_miss_ctrl
    import cpu_types_pkg::*;
#(
    parameter int SETS  = DCACHE_SETS,
    parameter int TAG_W = 26
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    dmemREN,
    input  logic                    dmemWEN,
    input  word_t                   dmemaddr,
    input  logic                    miss,
    input  logic                    lru_way,
    input  logic                    halt,
    output logic [$clog2(SETS)-1:0] frame_idx,
    output logic                    frame_way,
    input  logic                    frame_valid,
    input  logic                    frame_dirty,
    input  logic [TAG_W-1:0]        frame_tag,
    input  word_t [1:0]             frame_data,
    output logic                    fill_en,
    output logic                    fill_blkoff,
    output word_t                   fill_data,
    output logic                    fill_done,
    output logic                    clr_dirty,
    output logic                    busy,
    output logic                    flushed,
    output logic                    dREN,
    output logic                    dWEN,
    output word_t                   daddr,
    output word_t                   dstore,
    input  logic                    dwait,
    input  word_t                   dload
);

    localparam int IDX_W = $clog2(SETS);

    dcache_state_t    state;
    logic [IDX_W:0]   cnt;
    logic [IDX_W-1:0] vidx;
    logic             vway;
    logic             k;
    dcachef_t         req;
    logic             unused;

    assign req    = dcachef_t'(dmemaddr);
    assign unused = ^{req.blkoff, req.bytoff};
    assign busy   = (state != IDLE) && (state != FLUSHED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            vidx  <= '0;
            vway  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= FL_CHK;
                    end else if ((dmemREN || dmemWEN) && miss) begin
                        // victim frame is frozen here for the whole miss
                        vidx  <= req.idx;
                        vway  <= lru_way;
                        state <= (frame_dirty && frame_valid) ? WB0 : FETCH0;
                    end
                end
                WB0:     if (!dwait) state <= WB1;
                WB1:     if (!dwait) state <= FETCH0;
                FETCH0:  if (!dwait) state <= FETCH1;
                FETCH1:  if (!dwait) state <= FILL;
                FILL:    state <= IDLE;
                FL_CHK:  state <= (frame_valid && frame_dirty) ? FL_WB0 : FL_NXT;
                FL_WB0:  if (!dwait) state <= FL_WB1;
                FL_WB1:  if (!dwait) state <= FL_NXT;
                FL_NXT: begin
                    if (&cnt) begin
                        state <= FLUSHED;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= FL_CHK;
                    end
                end
                FLUSHED: state <= FLUSHED;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        frame_idx   = vidx;
        frame_way   = vway;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        fill_en     = 1'b0;
        fill_blkoff = 1'b0;
        fill_data   = '0;
        fill_done   = 1'b0;
        clr_dirty   = 1'b0;
        flushed     = 1'b0;
        k = (state == WB1) || (state == FETCH1) || (state == FL_WB1);
        case (state)
            IDLE: begin
                frame_idx = req.idx;
                frame_way = lru_way;
            end
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {frame_tag, frame_idx, k, 2'b00};
                dstore = frame_data[k];
            end
            FETCH0, FETCH1: begin
                dREN        = 1'b1;
                daddr       = {dmemaddr[31:3], k, 2'b00};
                fill_en     = !dwait;
                fill_blkoff = k;
                fill_data   = dwait ? '0 : dload;
            end
            FILL: fill_done = 1'b1;
            FL_CHK, FL_NXT: begin
                frame_idx = cnt[IDX_W:1];
                frame_way = cnt[0];
            end
            FL_WB0, FL_WB1: begin
                frame_idx = cnt[IDX_W:1];
                frame_way = cnt[0];
                dWEN      = 1'b1;
                daddr     = {frame_tag, frame_idx, k, 2'b00};
                dstore    = frame_data[k];
                clr_dirty = (state == FL_WB1) && !dwait;
            end
            FLUSHED: flushed = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a static frame-array model.
module tb_dcache_miss_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, miss, lru_way, halt;
    word_t       dmemaddr;
    logic [2:0]  frame_idx;
    logic        frame_way;
    logic        frame_valid, frame_dirty;
    logic [25:0] frame_tag;
    word_t [1:0] frame_data;
    logic        fill_en, fill_blkoff, fill_done, clr_dirty;
    word_t       fill_data;
    logic        busy, flushed, dREN, dWEN, dwait;
    word_t       daddr, dstore, dload;

    logic        fv [8][2];
    logic        fd [8][2];
    logic [25:0] ft [8][2];
    word_t       fw0 [8][2];
    word_t       fw1 [8][2];

    int checks = 0;
    int failures = 0;
    int nw, nren, nclr, nboth;
    word_t wa [4];
    word_t wd [4];

    always #5 CLK = ~CLK;

    assign frame_valid   = fv[frame_idx][frame_way];
    assign frame_dirty   = fd[frame_idx][frame_way];
    assign frame_tag     = ft[frame_idx][frame_way];
    assign frame_data[0] = fw0[frame_idx][frame_way];
    assign frame_data[1] = fw1[frame_idx][frame_way];

    dcache_miss_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .miss(miss), .lru_way(lru_way), .halt(halt),
        .frame_idx(frame_idx), .frame_way(frame_way),
        .frame_valid(frame_valid), .frame_dirty(frame_dirty),
        .frame_tag(frame_tag), .frame_data(frame_data),
        .fill_en(fill_en), .fill_blkoff(fill_blkoff), .fill_data(fill_data),
        .fill_done(fill_done), .clr_dirty(clr_dirty),
        .busy(busy), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_frames();
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 2; w++) begin
                fv[i][w]  = 1'b0;
                fd[i][w]  = 1'b0;
                ft[i][w]  = '0;
                fw0[i][w] = '0;
                fw1[i][w] = '0;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic run_flush();
        nw = 0; nren = 0; nclr = 0; nboth = 0;
        for (int c = 0; c < 200 && !flushed; c++) begin
            step();
            if (dWEN && !dwait) begin
                if (nw < 4) begin
                    wa[nw] = daddr;
                    wd[nw] = dstore;
                end
                nw++;
            end
            if (dREN) nren++;
            if (clr_dirty) nclr++;
            if (dREN && dWEN) nboth++;
        end
    endtask

    initial begin
        clear_frames();
        nRST = 1'b0; dmemREN = 0; dmemWEN = 0; miss = 0; lru_way = 0;
        halt = 0; dmemaddr = '0; dwait = 0; dload = '0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {dREN, dWEN, fill_en, fill_done, clr_dirty, flushed}, 0);
        chk("rst_daddr", daddr, 0);
        @(negedge CLK); nRST = 1'b1;

        // clean miss
        dmemREN = 1; dmemaddr = 32'h48; miss = 1; lru_way = 0;
        #1;
        chk("clean_idle_idx", frame_idx, 1);
        chk("clean_idle_busy", busy, 0);
        @(negedge CLK); dload = 32'hAAAA; #1;
        chk("clean_f0_ctl", {busy, dREN, dWEN, fill_en, fill_blkoff}, 5'b11010);
        chk("clean_f0_addr", daddr, 32'h48);
        chk("clean_f0_data", fill_data, 32'hAAAA);
        @(negedge CLK); dload = 32'hBBBB; #1;
        chk("clean_f1_ctl", {dREN, fill_en, fill_blkoff}, 3'b111);
        chk("clean_f1_addr", daddr, 32'h4C);
        chk("clean_f1_data", fill_data, 32'hBBBB);
        @(negedge CLK); miss = 0; #1;
        chk("clean_fill", {fill_done, dREN, fill_en, busy}, 4'b1001);
        step();
        chk("clean_back_idle", {busy, fill_done}, 0);
        dmemREN = 0;

        // dirty miss with stall in WB1
        fv[1][1] = 1; fd[1][1] = 1; ft[1][1] = 26'h1;
        fw0[1][1] = 32'h11; fw1[1][1] = 32'h22;
        fv[1][0] = 1; ft[1][0] = 26'h7;
        @(negedge CLK);
        dmemWEN = 1; dmemaddr = 32'h88; miss = 1; lru_way = 1;
        @(negedge CLK); lru_way = 0; #1;
        chk("dirty_wb0_ctl", {dWEN, dREN, frame_way}, 3'b101);
        chk("dirty_wb0_addr", daddr, 32'h48);
        chk("dirty_wb0_data", dstore, 32'h11);
        @(negedge CLK); dwait = 1; #1;
        for (int s = 0; s < 5; s++) begin
            chk("stall_addr", daddr, 32'h4C);
            chk("stall_data", dstore, 32'h22);
            chk("stall_ctl", {dWEN, dREN, frame_way, fill_en}, 4'b1010);
            step();
        end
        dwait = 0; #1;
        chk("stall_last_addr", daddr, 32'h4C);
        @(negedge CLK); dload = 32'h33; #1;
        chk("dirty_f0_ctl", {dREN, dWEN, frame_way, fill_en}, 4'b1011);
        chk("dirty_f0_addr", daddr, 32'h88);
        @(negedge CLK); dload = 32'h44; #1;
        chk("dirty_f1_addr", daddr, 32'h8C);
        chk("dirty_f1_way", frame_way, 1);
        @(negedge CLK); miss = 0; #1;
        chk("dirty_fill", {fill_done, frame_way, frame_idx}, 5'b11001);
        step();
        chk("dirty_idle", busy, 0);
        dmemWEN = 0;

        // async reset in FETCH1
        clear_frames();
        @(negedge CLK);
        dmemREN = 1; dmemaddr = 32'h48; miss = 1; lru_way = 0;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("rst_f1_dren", dREN, 1);
        #2 nRST = 0;
        #1;
        chk("rst_async_dren", {dREN, busy, fill_en}, 0);
        step();
        chk("rst_no_done", fill_done, 0);
        nRST = 1;
        #1;
        chk("rst_rel_idle", busy, 0);
        step();
        chk("rst_retry_f0", daddr, 32'h48);
        step();
        chk("rst_retry_f1", daddr, 32'h4C);
        @(negedge CLK); miss = 0; #1;
        chk("rst_retry_done", fill_done, 1);
        step();
        chk("rst_retry_idle", busy, 0);
        dmemREN = 0;

        // halt during FETCH0: fill completes, then flush
        @(negedge CLK);
        dmemREN = 1; dmemaddr = 32'h48; miss = 1;
        @(negedge CLK); halt = 1; #1;
        chk("halt_f0", {dREN, busy}, 2'b11);
        step();
        chk("halt_f1", {fill_en, fill_blkoff}, 2'b11);
        @(negedge CLK); miss = 0; dmemREN = 0; #1;
        chk("halt_fill_done", fill_done, 1);
        step();
        chk("halt_idle", busy, 0);
        step();
        chk("halt_flchk", {busy, dREN, dWEN}, 3'b100);
        run_flush();
        chk("halt_flushed", {flushed, busy}, 2'b10);
        chk("halt_flush_writes", nw, 0);

        // reset clears flushed; halt+miss same cycle with two dirty frames
        @(negedge CLK); nRST = 0; halt = 0; #1;
        chk("rst_flushed_clr", flushed, 0);
        @(negedge CLK); nRST = 1;
        fv[2][1] = 1; fd[2][1] = 1; ft[2][1] = 26'h5;
        fw0[2][1] = 32'hA0; fw1[2][1] = 32'hA1;
        fv[7][0] = 1; fd[7][0] = 1; ft[7][0] = 26'h3;
        fw0[7][0] = 32'hC0; fw1[7][0] = 32'hC1;
        fv[4][0] = 1; ft[4][0] = 26'h9;
        halt = 1; dmemREN = 1; dmemaddr = 32'h48; miss = 1;
        #1;
        chk("hm_idle", busy, 0);
        run_flush();
        chk("fl_done", flushed, 1);
        chk("fl_nwrites", nw, 4);
        chk("fl_ndren", nren, 0);
        chk("fl_nclr", nclr, 2);
        chk("fl_noboth", nboth, 0);
        chk("fl_a0", wa[0], 32'h150);
        chk("fl_d0", wd[0], 32'hA0);
        chk("fl_a1", wa[1], 32'h154);
        chk("fl_d1", wd[1], 32'hA1);
        chk("fl_a2", wa[2], 32'hF8);
        chk("fl_d2", wd[2], 32'hC0);
        chk("fl_a3", wa[3], 32'hFC);
        chk("fl_d3", wd[3], 32'hC1);
        halt = 0;
        step();
        step();
        chk("flushed_ignores", {flushed, busy, dREN, dWEN}, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
